// File: rtl/branch_resolve_unit.sv
// Branch resolution for miniRISC: evaluates branch conditions against the source
// register and the carry flag, produces registered next PC / link results, and squashes wrong-path slots.
module branch_resolve_unit #(
  parameter int WIDTH         = 32,
  parameter int PC_STEP       = 4,
  parameter int SQUASH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_valid,
  input  logic [2:0]       br_op,
  input  logic [WIDTH-1:0] rs_value,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] offset,
  input  logic             alu_carry,
  input  logic             flag_we,
  output logic             resolve_valid,
  output logic             taken,
  output logic [WIDTH-1:0] next_pc,
  output logic             link_we,
  output logic [WIDTH-1:0] link_value,
  output logic             illegal,
  output logic             squash,
  output logic             carry_flag
);

  typedef enum logic [2:0] {
    OP_BR   = 3'd0,
    OP_BLTZ = 3'd1,
    OP_BZ   = 3'd2,
    OP_BNZ  = 3'd3,
    OP_BL   = 3'd4,
    OP_BCY  = 3'd5,
    OP_BNCY = 3'd6,
    OP_RSVD = 3'd7
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_SQUASH
  } state_t;

  state_t           state;
  logic [2:0]       cnt;
  logic             accept;
  logic             cond;
  logic             eff_carry;
  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] tgt_pc;

  assign squash    = (cnt != '0);
  assign accept    = br_valid && !squash;
  // A flag write in the same cycle as the branch is forwarded ahead of the register.
  assign eff_carry = flag_we ? alu_carry : carry_flag;
  assign seq_pc    = pc + WIDTH'(PC_STEP);
  assign tgt_pc    = pc + offset;

  always_comb begin
    cond = 1'b0;
    case (br_op)
      OP_BR:   cond = 1'b1;
      OP_BLTZ: cond = rs_value[WIDTH-1];
      OP_BZ:   cond = (rs_value == '0);
      OP_BNZ:  cond = (rs_value != '0);
      OP_BL:   cond = 1'b1;
      OP_BCY:  cond = eff_carry;
      OP_BNCY: cond = !eff_carry;
      OP_RSVD: cond = 1'b0;
      default: cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      carry_flag    <= 1'b0;
      resolve_valid <= 1'b0;
      taken         <= 1'b0;
      next_pc       <= '0;
      link_we       <= 1'b0;
      link_value    <= '0;
      illegal       <= 1'b0;
    end else begin
      resolve_valid <= accept;
      taken         <= accept && cond;
      next_pc       <= accept ? (cond ? tgt_pc : seq_pc) : '0;
      link_we       <= accept && (br_op == OP_BL);
      link_value    <= accept ? seq_pc : '0;
      illegal       <= accept && (br_op == OP_RSVD);

      if (flag_we && !squash)
        carry_flag <= alu_carry;

      case (state)
        S_IDLE: begin
          if (accept && cond) begin
            state <= S_SQUASH;
            cnt   <= 3'(SQUASH_CYCLES);
          end
        end
        S_SQUASH: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1)
            state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: one instance with the default squash
// length and one with a three-cycle squash window, sharing the same stimulus.
module tb_branch_resolve_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        br_valid;
  logic [2:0]  br_op;
  logic [31:0] rs_value;
  logic [31:0] pc;
  logic [31:0] offset;
  logic        alu_carry;
  logic        flag_we;

  logic        o1_rv, o1_taken, o1_lwe, o1_ill, o1_sq, o1_cy;
  logic [31:0] o1_npc, o1_lv;
  logic        o3_rv, o3_taken, o3_lwe, o3_ill, o3_sq, o3_cy;
  logic [31:0] o3_npc, o3_lv;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .PC_STEP(4), .SQUASH_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .rs_value(rs_value),
    .pc(pc), .offset(offset), .alu_carry(alu_carry), .flag_we(flag_we),
    .resolve_valid(o1_rv), .taken(o1_taken), .next_pc(o1_npc), .link_we(o1_lwe),
    .link_value(o1_lv), .illegal(o1_ill), .squash(o1_sq), .carry_flag(o1_cy)
  );

  branch_resolve_unit #(.WIDTH(32), .PC_STEP(4), .SQUASH_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .rs_value(rs_value),
    .pc(pc), .offset(offset), .alu_carry(alu_carry), .flag_we(flag_we),
    .resolve_valid(o3_rv), .taken(o3_taken), .next_pc(o3_npc), .link_we(o3_lwe),
    .link_value(o3_lv), .illegal(o3_ill), .squash(o3_sq), .carry_flag(o3_cy)
  );

  task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] rs,
                       input logic [31:0] p, input logic [31:0] off,
                       input logic fwe, input logic cy);
    br_valid  = v;
    br_op     = op;
    rs_value  = rs;
    pc        = p;
    offset    = off;
    flag_we   = fwe;
    alu_carry = cy;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b1, 3'd0, 32'h0, 32'h100, 32'h10, 1'b1, 1'b1);
    tick();
    tick();
    checks++; if ({o1_rv, o1_taken, o1_lwe, o1_ill, o1_sq, o1_cy} !== 6'b0) begin errors++; $display("FAIL reset_flags_u1: got %b want 000000", {o1_rv, o1_taken, o1_lwe, o1_ill, o1_sq, o1_cy}); end
    checks++; if ({o1_npc, o1_lv} !== 64'h0) begin errors++; $display("FAIL reset_pc_u1: got %h want 0", {o1_npc, o1_lv}); end
    checks++; if ({o3_rv, o3_taken, o3_lwe, o3_ill, o3_sq, o3_cy} !== 6'b0) begin errors++; $display("FAIL reset_flags_u3: got %b want 000000", {o3_rv, o3_taken, o3_lwe, o3_ill, o3_sq, o3_cy}); end
    rst = 1'b0;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_bz_taken;
    drive(1'b1, 3'd2, 32'h0, 32'h100, 32'h20, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_lwe, o1_ill, o1_sq} !== 5'b11001) begin errors++; $display("FAIL bz_flags: got %b want 11001", {o1_rv, o1_taken, o1_lwe, o1_ill, o1_sq}); end
    checks++; if (o1_npc !== 32'h120) begin errors++; $display("FAIL bz_next_pc: got %h want 00000120", o1_npc); end
    checks++; if (o1_lv !== 32'h104) begin errors++; $display("FAIL bz_link_value: got %h want 00000104", o1_lv); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_lwe, o1_ill, o1_sq} !== 5'b0) begin errors++; $display("FAIL bz_after_flags: got %b want 00000", {o1_rv, o1_taken, o1_lwe, o1_ill, o1_sq}); end
    checks++; if ({o1_npc, o1_lv} !== 64'h0) begin errors++; $display("FAIL bz_after_pc: got %h want 0", {o1_npc, o1_lv}); end
  endtask

  task automatic test_bnz_squash;
    drive(1'b1, 3'd3, 32'h1, 32'h100, 32'h40, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_sq} !== 3'b111) begin errors++; $display("FAIL bnz_flags: got %b want 111", {o1_rv, o1_taken, o1_sq}); end
    checks++; if (o1_npc !== 32'h140) begin errors++; $display("FAIL bnz_next_pc: got %h want 00000140", o1_npc); end
    // branch and flag write during the squash slot must both be ignored
    drive(1'b1, 3'd0, 32'h0, 32'h200, 32'h10, 1'b1, 1'b1);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_sq} !== 3'b000) begin errors++; $display("FAIL dropped_flags: got %b want 000", {o1_rv, o1_taken, o1_sq}); end
    checks++; if (o1_cy !== 1'b0) begin errors++; $display("FAIL squash_carry_hold: got %b want 0", o1_cy); end
    drive(1'b1, 3'd2, 32'h5, 32'h300, 32'h80, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_sq} !== 3'b100) begin errors++; $display("FAIL after_drop_flags: got %b want 100", {o1_rv, o1_taken, o1_sq}); end
    checks++; if (o1_npc !== 32'h304) begin errors++; $display("FAIL after_drop_next_pc: got %h want 00000304", o1_npc); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_carry_bypass;
    drive(1'b1, 3'd5, 32'h0, 32'h400, 32'h80, 1'b1, 1'b1);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_sq, o1_cy} !== 4'b1111) begin errors++; $display("FAIL bcy_bypass_flags: got %b want 1111", {o1_rv, o1_taken, o1_sq, o1_cy}); end
    checks++; if (o1_npc !== 32'h480) begin errors++; $display("FAIL bcy_next_pc: got %h want 00000480", o1_npc); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd6, 32'h0, 32'h500, 32'h40, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_sq} !== 3'b100) begin errors++; $display("FAIL bncy_flags: got %b want 100", {o1_rv, o1_taken, o1_sq}); end
    checks++; if (o1_npc !== 32'h504) begin errors++; $display("FAIL bncy_next_pc: got %h want 00000504", o1_npc); end
    drive(1'b1, 3'd2, 32'h3, 32'h520, 32'h40, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken} !== 2'b10) begin errors++; $display("FAIL back_to_back_flags: got %b want 10", {o1_rv, o1_taken}); end
    checks++; if (o1_npc !== 32'h524) begin errors++; $display("FAIL back_to_back_next_pc: got %h want 00000524", o1_npc); end
    drive(1'b1, 3'd6, 32'h0, 32'h530, 32'h10, 1'b1, 1'b0);
    tick();
    checks++; if ({o1_taken, o1_cy} !== 2'b10) begin errors++; $display("FAIL bncy_bypass: got %b want 10", {o1_taken, o1_cy}); end
    checks++; if (o1_npc !== 32'h540) begin errors++; $display("FAIL bncy_bypass_next_pc: got %h want 00000540", o1_npc); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_bl_wrap;
    drive(1'b1, 3'd4, 32'h0, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_lwe, o1_ill} !== 4'b1110) begin errors++; $display("FAIL bl_flags: got %b want 1110", {o1_rv, o1_taken, o1_lwe, o1_ill}); end
    checks++; if (o1_npc !== 32'h4) begin errors++; $display("FAIL bl_next_pc: got %h want 00000004", o1_npc); end
    checks++; if (o1_lv !== 32'h0) begin errors++; $display("FAIL bl_link_value: got %h want 00000000", o1_lv); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (o1_lwe !== 1'b0) begin errors++; $display("FAIL bl_link_we_pulse: got %b want 0", o1_lwe); end
  endtask

  task automatic test_illegal_bltz;
    drive(1'b1, 3'd7, 32'h0, 32'h600, 32'h30, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_ill, o1_sq} !== 4'b1010) begin errors++; $display("FAIL illegal_flags: got %b want 1010", {o1_rv, o1_taken, o1_ill, o1_sq}); end
    checks++; if (o1_npc !== 32'h604) begin errors++; $display("FAIL illegal_next_pc: got %h want 00000604", o1_npc); end
    drive(1'b1, 3'd1, 32'h8000_0000, 32'h700, 32'hFFFF_FFF0, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken, o1_ill} !== 3'b110) begin errors++; $display("FAIL bltz_flags: got %b want 110", {o1_rv, o1_taken, o1_ill}); end
    checks++; if (o1_npc !== 32'h6F0) begin errors++; $display("FAIL bltz_next_pc: got %h want 000006f0", o1_npc); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 3'd1, 32'h7FFF_FFFF, 32'h710, 32'h40, 1'b0, 1'b0);
    tick();
    checks++; if ({o1_rv, o1_taken} !== 2'b10) begin errors++; $display("FAIL bltz_pos_flags: got %b want 10", {o1_rv, o1_taken}); end
    checks++; if (o1_npc !== 32'h714) begin errors++; $display("FAIL bltz_pos_next_pc: got %h want 00000714", o1_npc); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_squash3_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 3'd0, 32'h0, 32'h800, 32'h100, 1'b0, 1'b0);
    tick();
    checks++; if ({o3_rv, o3_taken, o3_sq} !== 3'b111) begin errors++; $display("FAIL sq3_br_flags: got %b want 111", {o3_rv, o3_taken, o3_sq}); end
    checks++; if (o3_npc !== 32'h900) begin errors++; $display("FAIL sq3_br_next_pc: got %h want 00000900", o3_npc); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    checks++; if (o3_sq !== 1'b1) begin errors++; $display("FAIL sq3_second_cycle: got %b want 1", o3_sq); end
    rst = 1'b1;
    drive(1'b1, 3'd0, 32'h0, 32'h900, 32'h10, 1'b1, 1'b1);
    tick();
    checks++; if ({o3_rv, o3_taken, o3_lwe, o3_ill, o3_sq, o3_cy} !== 6'b0) begin errors++; $display("FAIL sq3_reset_flags: got %b want 000000", {o3_rv, o3_taken, o3_lwe, o3_ill, o3_sq, o3_cy}); end
    checks++; if ({o3_npc, o3_lv} !== 64'h0) begin errors++; $display("FAIL sq3_reset_pc: got %h want 0", {o3_npc, o3_lv}); end
    rst = 1'b0;
    drive(1'b1, 3'd2, 32'h0, 32'hA00, 32'h4, 1'b0, 1'b0);
    tick();
    checks++; if ({o3_rv, o3_taken, o3_sq} !== 3'b111) begin errors++; $display("FAIL sq3_post_reset_flags: got %b want 111", {o3_rv, o3_taken, o3_sq}); end
    checks++; if (o3_npc !== 32'hA04) begin errors++; $display("FAIL sq3_post_reset_next_pc: got %h want 00000a04", o3_npc); end
    drive(1'b1, 3'd0, 32'h0, 32'hB00, 32'h10, 1'b0, 1'b0);
    tick();
    checks++; if ({o3_rv, o3_sq} !== 2'b01) begin errors++; $display("FAIL sq3_win_c2: got %b want 01", {o3_rv, o3_sq}); end
    tick();
    checks++; if ({o3_rv, o3_sq} !== 2'b01) begin errors++; $display("FAIL sq3_win_c3: got %b want 01", {o3_rv, o3_sq}); end
    tick();
    checks++; if ({o3_rv, o3_sq} !== 2'b00) begin errors++; $display("FAIL sq3_win_end: got %b want 00", {o3_rv, o3_sq}); end
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    test_reset();
    test_bz_taken();
    test_bnz_squash();
    test_carry_bypass();
    test_bl_wrap();
    test_illegal_bltz();
    test_squash3_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Consumer side of the processor's zero/condition-flag path. It registers the ALU carry flag and does its own zero and sign tests on the branch source register.
- Resolves the miniRISC branch opcodes to a taken/not-taken decision, a next PC and a link write.
- Sits between decode/ALU and the PC register. It holds a squash counter that kills the wrong-path slots after a taken branch.

Parameters:
- WIDTH, 32, data and PC width in bits.
- PC_STEP, 4, sequential PC increment.
- SQUASH_CYCLES, 1, number of issue cycles killed after a taken branch (1..7).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- br_valid  input  1  a branch instruction is presented this cycle.
- br_op  input  3  branch opcode, encoding listed under Behaviour.
- rs_value  input  WIDTH  source register operand tested by BLTZ/BZ/BNZ.
- pc  input  WIDTH  PC of the presented branch.
- offset  input  WIDTH  sign-extended branch displacement.
- alu_carry  input  1  carry out of the current ALU operation.
- flag_we  input  1  commit alu_carry into the carry flag.
- resolve_valid  output  1  registered; the outputs below describe one resolved branch.
- taken  output  1  registered branch decision.
- next_pc  output  WIDTH  registered: pc+offset if taken, else pc+PC_STEP.
- link_we  output  1  registered; write link_value to the link register.
- link_value  output  WIDTH  registered pc+PC_STEP.
- illegal  output  1  registered; reserved opcode seen.
- squash  output  1  high while the squash counter is nonzero.
- carry_flag  output  1  current registered carry flag.

Behaviour:
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output 0, carry flag 0, squash counter 0. Reset has priority over all other inputs and aborts a squash window in progress.
- Opcodes and their taken conditions:
  - 0 BR: always taken.
  - 1 BLTZ: taken if rs_value[WIDTH-1]=1.
  - 2 BZ: taken if rs_value==0 (full-width compare).
  - 3 BNZ: taken if rs_value!=0.
  - 4 BL: always taken; also link_we=1.
  - 5 BCY: taken if the effective carry is 1.
  - 6 BNCY: taken if the effective carry is 0.
  - 7: never taken; illegal=1; next_pc=pc+PC_STEP.
- Effective carry: when flag_we=1 in the same cycle as the branch, the effective carry is alu_carry (bypass). Otherwise it is the registered carry_flag.
- Latency: a branch accepted at edge N has its results visible from edge N. resolve_valid, taken, next_pc, link_we, link_value and illegal are each high for exactly one cycle and return to 0 the next cycle unless a new branch is accepted.
- Arithmetic: pc+offset and pc+PC_STEP are modulo 2^WIDTH. Wrap-around is silent, with no overflow flag.
- link_value is loaded with pc+PC_STEP on every accepted branch. link_we is 1 only for BL.
- Squash state machine, two states:
  - IDLE (counter=0) to SQUASH when an accepted branch is taken; the counter loads SQUASH_CYCLES.
  - In SQUASH, the counter decrements each cycle and the block returns to IDLE when it reaches 0.
  - squash equals (counter!=0).
- While squash=1:
  - br_valid is ignored; no resolve_valid and no counter reload.
  - flag_we is ignored; the carry flag holds.
- Accepted branches that are not taken, and illegal opcodes, never start a squash window.
- Back-to-back branches in IDLE with not-taken decisions are each accepted, one per cycle.
- Carry flag update: when flag_we=1 and squash=0, the flag takes alu_carry, independent of br_valid.

Test Plan:
- Reset, then BZ with rs_value=0, pc=0x100, offset=0x20 -> next cycle resolve_valid=1, taken=1, next_pc=0x120, squash=1 for 1 cycle, then all outputs 0.
- BNZ, rs=0x1, pc=0x100 -> taken=1, next_pc=0x100+offset. The branch presented on the next cycle is dropped with resolve_valid=0. The one after that is accepted.
- flag_we=1 with alu_carry=1 and BCY presented in the same cycle -> taken=1 (bypass). A later BNCY with no flag_we -> taken=0, next_pc=pc+4.
- BL at pc=0xFFFFFFFC, offset=8 -> taken=1, next_pc=0x4 (wrap), link_we=1, link_value=0x0.
- br_op=7 -> illegal=1, taken=0, squash stays 0. BLTZ with rs=0x80000000 -> taken=1.
- SQUASH_CYCLES=3, taken BR then rst asserted during the second squash cycle -> squash=0 and every output 0 after the reset edge. The next branch is accepted normally.
